// File: rtl/stack_sequence_controller.sv
// Sequencer for CALL, RET, RTI and interrupt entry in decode: moves a 32-bit PC
// and the flags through the 16-bit stack path one word per cycle.
module stack_sequence_controller (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Hold,
    input  logic       Call,
    input  logic       Ret,
    input  logic       Rti,
    input  logic       IntPin,
    output logic       Stall,
    output logic       SecondIter,
    output logic       Flush,
    output logic       Push,
    output logic       Pop,
    output logic [1:0] StackSel,
    output logic       IntAck,
    output logic       Busy
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, FLUSH} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_CALL, OP_INT, OP_RET, OP_RTI} op_t;

    localparam logic [1:0] SEL_LO    = 2'b00;
    localparam logic [1:0] SEL_HI    = 2'b01;
    localparam logic [1:0] SEL_FLAGS = 2'b10;

    state_t state, next_state;
    op_t    op, next_op;
    logic   int_pin_d, int_pending, int_rise, take_int;
    logic   word_step, is_push_op, is_pop_op;

    assign int_rise = IntPin & ~int_pin_d;

    // A new edge in the same cycle the interrupt is taken keeps the request pending.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            op          <= OP_NONE;
            int_pin_d   <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            state     <= next_state;
            op        <= next_op;
            int_pin_d <= IntPin;
            if (int_rise)
                int_pending <= 1'b1;
            else if (take_int)
                int_pending <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        next_op    = op;
        take_int   = 1'b0;
        if (!Hold) begin
            case (state)
                IDLE: begin
                    if (Rti) begin
                        next_state = S1;
                        next_op    = OP_RTI;
                    end else if (Ret) begin
                        next_state = S1;
                        next_op    = OP_RET;
                    end else if (Call) begin
                        next_state = S1;
                        next_op    = OP_CALL;
                    end else if (int_pending) begin
                        next_state = S1;
                        next_op    = OP_INT;
                        take_int   = 1'b1;
                    end
                end
                S1:      next_state = S2;
                S2:      next_state = (op == OP_INT || op == OP_RTI) ? S3 : FLUSH;
                S3:      next_state = FLUSH;
                FLUSH: begin
                    next_state = IDLE;
                    next_op    = OP_NONE;
                end
                default: begin
                    next_state = IDLE;
                    next_op    = OP_NONE;
                end
            endcase
        end
    end

    assign is_push_op = (op == OP_CALL) || (op == OP_INT);
    assign is_pop_op  = (op == OP_RET)  || (op == OP_RTI);

    // Hold only masks the one-shot strobes; the step-describing outputs stay visible.
    always_comb begin
        Stall      = 1'b0;
        SecondIter = 1'b0;
        Flush      = 1'b0;
        IntAck     = 1'b0;
        StackSel   = SEL_LO;
        word_step  = 1'b0;
        Busy       = (state != IDLE);
        case (state)
            S1: begin
                Stall     = 1'b1;
                word_step = 1'b1;
                case (op)
                    OP_CALL: StackSel = SEL_HI;
                    OP_INT:  StackSel = SEL_FLAGS;
                    default: StackSel = SEL_LO;
                endcase
            end
            S2: begin
                Stall      = 1'b1;
                SecondIter = 1'b1;
                word_step  = 1'b1;
                StackSel   = (op == OP_CALL) ? SEL_LO : SEL_HI;
            end
            S3: begin
                Stall      = 1'b1;
                SecondIter = 1'b1;
                word_step  = 1'b1;
                StackSel   = (op == OP_RTI) ? SEL_FLAGS : SEL_LO;
            end
            FLUSH: begin
                Flush  = ~Hold;
                IntAck = ~Hold & (op == OP_INT);
            end
            default: ;
        endcase
        Push = word_step & is_push_op & ~Hold;
        Pop  = word_step & is_pop_op  & ~Hold;
    end

endmodule

// File: tb/tb_stack_sequence_controller.sv
// Self-checking bench: directed scenarios plus random traffic, all compared each
// cycle against a word-list model of the stack sequences.
module tb_stack_sequence_controller;

    logic       Clk = 1'b0;
    logic       Rst, Hold, Call, Ret, Rti, IntPin;
    logic       Stall, SecondIter, Flush, Push, Pop, IntAck, Busy;
    logic [1:0] StackSel;

    int vectors     = 0;
    int miscompares = 0;
    int push_cnt    = 0;
    int pop_cnt     = 0;
    int ack_cnt     = 0;

    stack_sequence_controller dut (
        .Clk(Clk), .Rst(Rst), .Hold(Hold), .Call(Call), .Ret(Ret), .Rti(Rti),
        .IntPin(IntPin), .Stall(Stall), .SecondIter(SecondIter), .Flush(Flush),
        .Push(Push), .Pop(Pop), .StackSel(StackSel), .IntAck(IntAck), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Model: 0 idle, 1 moving words from a list, 2 flush cycle.
    int         m_phase   = 0;
    int         m_len     = 0;
    int         m_pos     = 0;
    bit         m_is_push = 1'b0;
    bit         m_is_int  = 1'b0;
    bit         m_pending = 1'b0;
    bit         m_prev    = 1'b0;
    logic [1:0] m_words[3];

    task automatic load_seq(input int kind);
        m_phase = 1;
        m_pos   = 0;
        case (kind)
            0: begin m_words = '{2'b01, 2'b00, 2'b00}; m_len = 2; m_is_push = 1'b1; m_is_int = 1'b0; end
            1: begin m_words = '{2'b10, 2'b01, 2'b00}; m_len = 3; m_is_push = 1'b1; m_is_int = 1'b1; end
            2: begin m_words = '{2'b00, 2'b01, 2'b00}; m_len = 2; m_is_push = 1'b0; m_is_int = 1'b0; end
            default: begin m_words = '{2'b00, 2'b01, 2'b10}; m_len = 3; m_is_push = 1'b0; m_is_int = 1'b0; end
        endcase
    endtask

    always @(posedge Clk) begin : model
        bit rise;
        bit took_int;
        if (Rst) begin
            m_phase   = 0;
            m_pos     = 0;
            m_pending = 1'b0;
            m_prev    = 1'b0;
            m_is_int  = 1'b0;
        end else begin
            rise     = IntPin && !m_prev;
            took_int = 1'b0;
            if (!Hold) begin
                case (m_phase)
                    0: begin
                        if (Rti)            load_seq(3);
                        else if (Ret)       load_seq(2);
                        else if (Call)      load_seq(0);
                        else if (m_pending) begin load_seq(1); took_int = 1'b1; end
                    end
                    1: begin
                        m_pos++;
                        if (m_pos == m_len) m_phase = 2;
                    end
                    default: m_phase = 0;
                endcase
            end
            if (rise)          m_pending = 1'b1;
            else if (took_int) m_pending = 1'b0;
            m_prev = IntPin;
        end
    end

    function automatic void chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_sel(input string name, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_cnt(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge Clk) begin : compare
        logic       ex_stall, ex_second, ex_flush, ex_push, ex_pop, ex_ack, ex_busy;
        logic [1:0] ex_sel;
        ex_stall = 1'b0; ex_second = 1'b0; ex_flush = 1'b0; ex_push = 1'b0;
        ex_pop   = 1'b0; ex_ack    = 1'b0; ex_busy  = 1'b0; ex_sel  = 2'b00;
        if (!Rst) begin
            if (m_phase == 1) begin
                ex_stall  = 1'b1;
                ex_busy   = 1'b1;
                ex_second = (m_pos > 0);
                ex_sel    = m_words[m_pos];
                ex_push   = m_is_push && !Hold;
                ex_pop    = !m_is_push && !Hold;
            end else if (m_phase == 2) begin
                ex_busy  = 1'b1;
                ex_flush = !Hold;
                ex_ack   = m_is_int && !Hold;
            end
            push_cnt += int'(Push);
            pop_cnt  += int'(Pop);
            ack_cnt  += int'(IntAck);
        end
        chk_bit("Stall", Stall, ex_stall);
        chk_bit("SecondIter", SecondIter, ex_second);
        chk_bit("Flush", Flush, ex_flush);
        chk_bit("Push", Push, ex_push);
        chk_bit("Pop", Pop, ex_pop);
        chk_bit("IntAck", IntAck, ex_ack);
        chk_bit("Busy", Busy, ex_busy);
        chk_sel("StackSel", StackSel, ex_sel);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus();
        int p, q, a;
        Rst = 1'b1; Hold = 1'b0; Call = 1'b0; Ret = 1'b0; Rti = 1'b0; IntPin = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        #1;
        chk_bit("reset_busy", Busy, 1'b0);
        chk_bit("reset_stall", Stall, 1'b0);
        chk_bit("reset_push", Push, 1'b0);

        // CALL: HI then LO, flush, idle
        p = push_cnt;
        Call = 1'b1; tick(); Call = 1'b0;
        chk_bit("call_s1_push", Push, 1'b1);
        chk_sel("call_s1_sel", StackSel, 2'b01);
        chk_bit("call_s1_second", SecondIter, 1'b0);
        tick();
        chk_bit("call_s2_push", Push, 1'b1);
        chk_sel("call_s2_sel", StackSel, 2'b00);
        chk_bit("call_s2_second", SecondIter, 1'b1);
        tick();
        chk_bit("call_flush", Flush, 1'b1);
        chk_bit("call_flush_stall", Stall, 1'b0);
        tick();
        chk_bit("call_idle", Busy, 1'b0);
        chk_cnt("call_push_count", push_cnt - p, 2);

        // Level-high interrupt serviced exactly once
        p = push_cnt; a = ack_cnt;
        IntPin = 1'b1;
        repeat (10) tick();
        IntPin = 1'b0;
        repeat (3) tick();
        chk_cnt("int_push_count", push_cnt - p, 3);
        chk_cnt("int_ack_count", ack_cnt - a, 1);

        // RTI with Hold across S2
        q = pop_cnt;
        Rti = 1'b1; tick(); Rti = 1'b0;
        chk_sel("rti_s1_sel", StackSel, 2'b00);
        tick();
        Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_bit("rti_hold_pop", Pop, 1'b0);
            chk_bit("rti_hold_stall", Stall, 1'b1);
            chk_bit("rti_hold_second", SecondIter, 1'b1);
            tick();
        end
        Hold = 1'b0;
        #1;
        chk_bit("rti_s2_pop", Pop, 1'b1);
        chk_sel("rti_s2_sel", StackSel, 2'b01);
        tick();
        chk_sel("rti_s3_sel", StackSel, 2'b10);
        tick();
        chk_bit("rti_flush", Flush, 1'b1);
        tick();
        chk_cnt("rti_pop_count", pop_cnt - q, 3);

        // CALL and interrupt edge together: CALL first
        p = push_cnt; a = ack_cnt;
        Call = 1'b1; IntPin = 1'b1; tick(); Call = 1'b0;
        chk_sel("callint_first_sel", StackSel, 2'b01);
        repeat (10) tick();
        IntPin = 1'b0;
        tick();
        chk_cnt("callint_push_count", push_cnt - p, 5);
        chk_cnt("callint_ack_count", ack_cnt - a, 1);

        // RET beats CALL
        p = push_cnt; q = pop_cnt;
        Ret = 1'b1; Call = 1'b1; tick(); Ret = 1'b0; Call = 1'b0;
        chk_bit("retcall_pop", Pop, 1'b1);
        repeat (4) tick();
        chk_cnt("retcall_push_count", push_cnt - p, 0);
        chk_cnt("retcall_pop_count", pop_cnt - q, 2);

        // Reset during INT S2 with another edge already pending
        IntPin = 1'b1; tick(); IntPin = 1'b0; tick();
        chk_sel("rst_int_s1_sel", StackSel, 2'b10);
        IntPin = 1'b1; tick();
        chk_sel("rst_int_s2_sel", StackSel, 2'b01);
        #2 Rst = 1'b1; IntPin = 1'b0;
        #1;
        chk_bit("rst_async_busy", Busy, 1'b0);
        chk_bit("rst_async_push", Push, 1'b0);
        chk_bit("rst_async_stall", Stall, 1'b0);
        chk_sel("rst_async_sel", StackSel, 2'b00);
        p = push_cnt;
        tick(); Rst = 1'b0;
        repeat (8) tick();
        chk_cnt("rst_push_after", push_cnt - p, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            Hold = ($urandom_range(0, 3) == 0);
            Call = ($urandom_range(0, 4) == 0);
            Ret  = ($urandom_range(0, 6) == 0);
            Rti  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) IntPin = ~IntPin;
            tick();
        end
        Hold = 1'b0; Call = 1'b0; Ret = 1'b0; Rti = 1'b0;
        repeat (12) tick();
    endtask

    task automatic checkOutput();
        chk_bit("final_idle", Busy, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $finish;
    end

endmodule
